// File: rtl/shreg_ctrl.sv
// Host-side driver for a serial storage chain: shifts parallel write words in and returns the bits
// that fall out as parallel read words. Define SHREG_CTRL_LSB_FIRST_EN for LSB-first shifting.
`timescale 1ns/1ps
module shreg_ctrl #(
  parameter int CHAIN_LEN = 1600,
  parameter int WORD_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              shreg_enable,
  output logic              shreg_in,
  input  logic              shreg_out
);
  localparam int NWORDS = CHAIN_LEN / WORD_W;
  localparam int BCW    = $clog2(WORD_W + 1);
  localparam int WCW    = $clog2(NWORDS + 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(WORD_W - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    PUSH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [WORD_W-1:0] tx_r, rx_r;
  logic [WORD_W-1:0] tx_load_s, tx_next_s, rx_next_s;
  logic              tx_first_s, tx_bit_s;
  logic [BCW-1:0]    bit_cnt_r;
  logic [WCW-1:0]    word_cnt_r;
  logic              wr_fire_s, rd_fire_s, last_shift_s;

  assign wr_fire_s    = (state_r == LOAD) && wr_valid && wr_ready;
  assign rd_fire_s    = (state_r == PUSH) && rd_valid && rd_ready;
  assign last_shift_s = (state_r == SHIFT) && (bit_cnt_r == LAST_BIT);

  // Shift direction of the TX and RX words; the chain itself always shifts toward its MSB end.
  always_comb begin
`ifdef SHREG_CTRL_LSB_FIRST_EN
    tx_load_s  = wr_data >> 1;
    tx_first_s = wr_data[0];
    tx_next_s  = tx_r >> 1;
    tx_bit_s   = tx_r[0];
    rx_next_s  = {shreg_out, rx_r[WORD_W-1:1]};
`else
    tx_load_s  = wr_data << 1;
    tx_first_s = wr_data[WORD_W-1];
    tx_next_s  = tx_r << 1;
    tx_bit_s   = tx_r[WORD_W-1];
    rx_next_s  = {rx_r[WORD_W-2:0], shreg_out};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = LOAD; else state_s = IDLE;
      LOAD:    if (wr_fire_s) state_s = SHIFT; else state_s = LOAD;
      SHIFT:   if (last_shift_s) state_s = PUSH; else state_s = SHIFT;
      PUSH: begin
        if (rd_fire_s) state_s = (word_cnt_r == LAST_WORD) ? DONE : LOAD;
        else           state_s = PUSH;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      wr_ready     <= 1'b0;
      rd_valid     <= 1'b0;
      shreg_enable <= 1'b0;
      shreg_in     <= 1'b0;
      rd_data      <= '0;
      tx_r         <= '0;
      rx_r         <= '0;
      bit_cnt_r    <= '0;
      word_cnt_r   <= '0;
    end else begin
      busy         <= (state_s == LOAD) || (state_s == SHIFT) || (state_s == PUSH);
      done         <= (state_s == DONE);
      wr_ready     <= (state_s == LOAD);
      rd_valid     <= (state_s == PUSH);
      shreg_enable <= (state_s == SHIFT);
      if (wr_fire_s) begin
        tx_r      <= tx_load_s;
        shreg_in  <= tx_first_s;
        bit_cnt_r <= '0;
      end else if (state_r == SHIFT) begin
        tx_r      <= tx_next_s;
        shreg_in  <= last_shift_s ? 1'b0 : tx_bit_s;
        bit_cnt_r <= bit_cnt_r + BCW'(1);
      end
      // The chain shifts on this same edge, so shreg_out is still the pre-shift MSB.
      if (shreg_enable) rx_r <= rx_next_s;
      if (last_shift_s) rd_data <= rx_next_s;
      if ((state_r == IDLE) && start) word_cnt_r <= '0;
      else if (rd_fire_s)             word_cnt_r <= word_cnt_r + WCW'(1);
    end
  end
endmodule

// File: tb/tb_shreg_ctrl.sv
// Self-checking bench for shreg_ctrl: a 64-bit behavioural chain, a directed vector table,
// a reset-mid-frame sequence and randomized frames checked against a bit-queue reference model.
`timescale 1ns/1ps
module tb_shreg_ctrl;
  localparam int CL = 64;
  localparam int W  = 32;
  localparam int NW = CL / W;
`ifdef SHREG_CTRL_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, wr_valid, rd_ready;
  logic [W-1:0]  wr_data;
  logic          busy, done, wr_ready, rd_valid, shreg_enable, shreg_in, shreg_out;
  logic [W-1:0]  rd_data;

  always #5 clk = ~clk;

  shreg_ctrl #(.CHAIN_LEN(CL), .WORD_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .shreg_enable(shreg_enable), .shreg_in(shreg_in), .shreg_out(shreg_out)
  );

  // Behavioural chain plus shift and busy-fall monitors.
  logic [CL-1:0] chain = '0;
  logic [CL-1:0] load_val = '0;
  logic          load_req = 1'b0;
  logic          en_clr = 1'b0;
  logic          busy_q = 1'b0;
  int            en_cnt = 0;
  int            busy_falls = 0;
  assign shreg_out = chain[CL-1];

  always @(posedge clk) begin
    if (load_req)          chain <= load_val;
    else if (shreg_enable) chain <= {chain[CL-2:0], shreg_in};
    if (en_clr)            en_cnt <= 0;
    else if (shreg_enable) en_cnt <= en_cnt + 1;
    busy_q <= busy;
    if (en_clr)                  busy_falls <= 0;
    else if (busy_q && !busy)    busy_falls <= busy_falls + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: the chain is a bit queue (front = chain MSB); each shift pops the front and
  // appends the new bit; bits travel in the order chosen by the shift direction.
  function automatic void model_frame(input logic [CL-1:0] pre, input logic [CL-1:0] wr,
                                      output logic [CL-1:0] rd, output logic [CL-1:0] post);
    bit q[$];
    logic [W-1:0] w, r;
    int idx;
    r = '0;
    for (int i = CL - 1; i >= 0; i--) q.push_back(pre[i]);
    for (int k = 0; k < NW; k++) begin
      w = wr[CL-1-k*W -: W];
      for (int b = 0; b < W; b++) begin
        idx = LSB_FIRST ? b : W - 1 - b;
        r[idx] = q.pop_front();
        q.push_back(w[idx]);
      end
      rd[CL-1-k*W -: W] = r;
    end
    for (int i = CL - 1; i >= 0; i--) post[i] = q.pop_front();
  endfunction

  task automatic run_frame(input string tag, input logic [CL-1:0] pre, input logic [CL-1:0] wr,
                           input logic [CL-1:0] exp_rd, input logic [CL-1:0] exp_post,
                           input int wr_gap, input int rd_gap, input bit poke,
                           input int exp_cycles, input bit abort);
    int edges;
    int n;
    @(negedge clk);
    load_req = 1'b1; load_val = pre; en_clr = 1'b1;
    @(negedge clk);
    load_req = 1'b0; en_clr = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    for (int k = 0; k < NW; k++) begin
      repeat (wr_gap) begin @(negedge clk); edges++; end
      wr_valid = 1'b1;
      wr_data  = wr[CL-1-k*W -: W];
      for (int t = 0; t < 200 && !wr_ready; t++) begin @(negedge clk); edges++; end
      check({tag, " wr_ready"}, 64'(wr_ready), 64'd1);
      @(negedge clk); edges++;
      wr_valid = 1'b0;
      wr_data  = $urandom;
      if (poke && k == 0) begin
        start = 1'b1;
        @(negedge clk); edges++;
        start = 1'b0;
      end
      if (abort && k == 1) begin
        n = 0;
        while (n < 10 && edges < 2000) begin
          if (shreg_enable) n++;
          if (n < 10) begin @(negedge clk); edges++; end
        end
        check({tag, " tenth shift reached"}, 64'(n), 64'd10);
        rst = 1'b0;
        #1;
        check({tag, " async reset outputs"},
              64'({busy, done, wr_ready, rd_valid, shreg_enable, shreg_in, rd_data}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      for (int t = 0; t < 200 && !rd_valid; t++) begin @(negedge clk); edges++; end
      check({tag, " rd_valid"}, 64'(rd_valid), 64'd1);
      repeat (rd_gap) begin
        @(negedge clk); edges++;
        check({tag, " rd held while stalled"}, 64'({rd_valid, rd_data}),
              64'({1'b1, exp_rd[CL-1-k*W -: W]}));
      end
      check($sformatf("%s rd word %0d", tag, k), 64'(rd_data), 64'(exp_rd[CL-1-k*W -: W]));
      rd_ready = 1'b1;
      @(negedge clk); edges++;
      rd_ready = 1'b0;
    end
    for (int t = 0; t < 200 && !done; t++) begin @(negedge clk); edges++; end
    check({tag, " done/busy"}, 64'({done, busy}), 64'b10);
    // Cycles are counted inclusive of the start cycle and the done cycle.
    check({tag, " start-to-done cycles"}, 64'(edges + 1), 64'(exp_cycles));
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " done is one pulse"}, 64'(done), 64'd0);
    repeat (20) @(negedge clk);
    check({tag, " idle after frame"}, 64'({busy, wr_ready, rd_valid, shreg_enable}), 64'd0);
    check({tag, " shift count"}, 64'(en_cnt), 64'(CL));
    check({tag, " busy falls"}, 64'(busy_falls), 64'd1);
    check({tag, " chain after frame"}, chain, exp_post);
  endtask

  typedef struct {
    logic [CL-1:0] pre;
    logic [CL-1:0] wr;
    int            wr_gap;
    int            rd_gap;
    bit            poke;
    logic [CL-1:0] exp_rd;
    logic [CL-1:0] exp_post;
    int            exp_cycles;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [CL-1:0] pre, wr, erd, epost;
    int g_wr, g_rd;
    bit pk;

`ifdef SHREG_CTRL_LSB_FIRST_EN
    tbl[0] = '{64'h0, 64'h00000001_00000000, 0, 0, 1'b0,
               64'h0, 64'h80000000_00000000, 70};
    tbl[1] = '{64'hDEADBEEF_CAFEF00D, 64'h0, 5, 7, 1'b0,
               64'hF77DB57B_B00F7F53, 64'h0, 94};
    tbl[2] = '{64'hDEADBEEF_CAFEF00D, 64'h0, 0, 0, 1'b1,
               64'hF77DB57B_B00F7F53, 64'h0, 70};
`else
    tbl[0] = '{64'hDEADBEEF_CAFEF00D, 64'h12345678_9ABCDEF0, 0, 0, 1'b0,
               64'hDEADBEEF_CAFEF00D, 64'h12345678_9ABCDEF0, 70};
    tbl[1] = '{64'hDEADBEEF_CAFEF00D, 64'h12345678_9ABCDEF0, 5, 7, 1'b0,
               64'hDEADBEEF_CAFEF00D, 64'h12345678_9ABCDEF0, 94};
    tbl[2] = '{64'h0123456789ABCDEF, 64'hA5A5A5A5_5A5A5A5A, 0, 0, 1'b1,
               64'h0123456789ABCDEF, 64'hA5A5A5A5_5A5A5A5A, 70};
`endif
    tbl[3] = '{64'hFFFFFFFF_FFFFFFFF, 64'h0, 0, 0, 1'b0,
               64'hFFFFFFFF_FFFFFFFF, 64'h0, 70};

    rst = 1'b0; start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle outputs cycle %0d", i),
            64'({busy, done, wr_ready, rd_valid, shreg_enable, shreg_in, rd_data}), 64'd0);
    end
    check("idle shift count", 64'(en_cnt), 64'd0);

    for (int i = 0; i < 4; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].pre, tbl[i].wr, tbl[i].exp_rd, tbl[i].exp_post,
                tbl[i].wr_gap, tbl[i].rd_gap, tbl[i].poke, tbl[i].exp_cycles, 1'b0);

    pre = {$urandom, $urandom};
    wr  = {$urandom, $urandom};
    model_frame(pre, wr, erd, epost);
    run_frame("abort", pre, wr, erd, epost, 0, 0, 1'b0, 70, 1'b1);

    for (int i = 0; i < 8; i++) begin
      pre  = {$urandom, $urandom};
      wr   = {$urandom, $urandom};
      g_wr = $urandom_range(0, 3);
      g_rd = $urandom_range(0, 3);
      pk   = 1'($urandom_range(0, 1));
      model_frame(pre, wr, erd, epost);
      run_frame($sformatf("rand%0d", i), pre, wr, erd, epost, g_wr, g_rd, pk,
                70 + NW * (g_wr + g_rd), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/shreg_ctrl.md
Name: shreg_ctrl

Overview:
- Host-side driver for the serial storage chain (`shreg_enable`/`shreg_in`/`shreg_out` interface).
- Serializes parallel write words into the chain while capturing the bits that fall out of the chain end, and returns them as parallel read words.
- One frame = `CHAIN_LEN` shifts, so a full frame replaces the chain contents and reads back the previous contents.
- Sits between the configuration bus/host FSM and one chain instance.

Parameters:
- `CHAIN_LEN`, 1600: chain length in bits; one frame shifts exactly this many bits.
- `WORD_W`, 32: parallel word width; `CHAIN_LEN` must be a multiple of `WORD_W`, so words per frame `NWORDS` = `CHAIN_LEN`/`WORD_W`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a frame; ignored while `busy`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last read word is accepted.
- `wr_data`  in  `WORD_W`  next word to shift into the chain.
- `wr_valid`  in  1  `wr_data` valid.
- `wr_ready`  out  1  controller accepts `wr_data` this cycle.
- `rd_data`  out  `WORD_W`  word captured from the chain output.
- `rd_valid`  out  1  `rd_data` valid; held until accepted.
- `rd_ready`  in  1  consumer accepts `rd_data`.
- `shreg_enable`  out  1  chain shift enable (registered).
- `shreg_in`  out  1  serial data into the chain (registered).
- `shreg_out`  in  1  serial data from the chain end.

Behaviour:
- Reset (`rst`=0, async, any state): state IDLE; `busy`, `done`, `wr_ready`, `rd_valid`, `shreg_enable`, `shreg_in` = 0; `rd_data`, word counter and bit counter = 0.
- IDLE:
  - `start`=1 → LOAD; `busy`=1 from the next cycle; word counter = 0.
- LOAD:
  - `wr_ready`=1.
  - On `wr_valid`&&`wr_ready`, latch the word into the TX shift reg, bit counter = 0, go to SHIFT.
  - `wr_valid` low: wait indefinitely with `shreg_enable`=0.
- SHIFT: exactly `WORD_W` consecutive cycles with `shreg_enable`=1, no gaps.
  - `shreg_in` = TX reg MSB; TX reg shifts left each cycle (MSB-first).
  - Capture: on every clock edge where `shreg_enable`=1, the RX reg shifts left and takes `shreg_out` at bit 0. The chain shifts on the same edge, so the captured bit is the pre-shift chain MSB.
  - After the `WORD_W`th shift: `shreg_enable`=0, RX reg → `rd_data`, `rd_valid`=1, go to PUSH.
- PUSH:
  - Hold `rd_data` stable until `rd_valid`&&`rd_ready`.
  - On acceptance: word counter += 1.
    - If word counter was `NWORDS`-1: → DONE.
    - Otherwise: → LOAD.
- DONE: `done`=1 for one cycle, `busy`=0 at the same edge; → IDLE.
- Ordering:
  - Read word k holds chain bits [`CHAIN_LEN`-1-k·`WORD_W` -: `WORD_W`] of the pre-frame contents.
  - Write word 0 ends up in the chain's top `WORD_W` bits after the frame.
- Shift gaps between words are allowed: the chain holds while `shreg_enable`=0, so backpressure never corrupts data.
- Minimum frame latency: `start` to `done` = 1 + `NWORDS`·(`WORD_W`+2) + 1 cycles, with `wr_valid`/`rd_ready` constantly high.
- Simultaneous events:
  - `start` while `busy`: ignored.
  - `start` in the DONE cycle: ignored.
  - `wr_valid` outside LOAD: not accepted.
- Reset mid-frame: controller returns to IDLE immediately. Chain contents are partial and undefined; the host must rerun a full frame.
- Counter widths: `$clog2(WORD_W+1)` and `$clog2(NWORDS+1)`; no wrap within a frame.

Optional Feature:
- Macro: `SHREG_CTRL_LSB_FIRST_EN`.
- Defined:
  - TX reg shifts right; `shreg_in` = TX LSB.
  - RX reg shifts right, inserting `shreg_out` at bit `WORD_W`-1, so read words come back bit-reversed relative to the MSB-first mode (LSB-first convention on both sides).
- Undefined: MSB-first as described above.
- Handshake, timing and word order are identical in both modes.

Test Plan:
- Bench: `CHAIN_LEN`=64, `WORD_W`=32, behavioural 64-bit chain model.
- Reset then idle 10 cycles → all outputs 0, `shreg_enable` never asserted.
- Chain preloaded 0xDEADBEEF_CAFEF00D; frame writing 0x12345678, 0x9ABCDEF0 with `wr_valid`/`rd_ready` always 1:
  - reads 0xDEADBEEF then 0xCAFEF00D;
  - chain afterwards = 0x12345678_9ABCDEF0;
  - `done` exactly 70 cycles after `start`.
- Same frame with `wr_valid` delayed 5 cycles and `rd_ready` low 7 cycles per word → same data; `shreg_enable` count = 64 total; `rd_data` stable while stalled.
- `start` pulsed while `busy` and in the DONE cycle → no second frame; `busy` drops once.
- `rst` low during the 10th shift of word 1 → all outputs 0 asynchronously (before the next edge); new frame afterwards completes correctly.
- With `SHREG_CTRL_LSB_FIRST_EN`, write 0x00000001, 0x00000000 into a zeroed chain → chain bit 63 = 1, all other bits 0.
